// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared width, default burst length and drain-state type for the FIFO read stream.
package fifo_rd_stream_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN_DEF = 4;
    typedef enum logic [1:0] {IDLE, RUN, FULL} st_t;
    function automatic st_t st_of(logic [1:0] occ, logic inflight);
        return occ == 2'd2 ? FULL : (occ == 2'd1 || inflight) ? RUN : IDLE;
    endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO consumer-side and valid/ready stream signals of the read drain stage.
interface fifo_rd_stream_if #(parameter int DW = 8);
    logic fifo_empty;
    logic [DW-1:0] data_out;
    logic rd_req;
    logic [DW-1:0] m_data;
    logic m_valid;
    logic m_ready;
    logic m_last;
    modport master (input fifo_empty, data_out, m_ready, output rd_req, m_data, m_valid, m_last);
    modport slave (output fifo_empty, data_out, m_ready, input rd_req, m_data, m_valid, m_last);
endinterface

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry skid buffer with head/tail pointers and occupancy count.
module fifo_rd_skid #(parameter int DW = 8) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    occ
);
    logic [DW-1:0] mem [2];
    logic head, tail;
    assign dout = mem[head];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head <= 1'b0;
            tail <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (push) begin
                mem[tail] <= din;
                tail <= ~tail;
            end
            if (pop) head <= ~head;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read side into a framed valid/ready stream.
// Optional FIFO_RD_STATS_EN adds a saturating accepted-beat counter rd_count.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic r_clk,
    input  logic rrst,
    fifo_rd_stream_if.master bus
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0] rd_count
`endif
);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
    logic inflight, pop;
    logic [1:0] occ, occ_nx;
    logic [2:0] credit;
    logic [BW-1:0] beat;
    st_t st, st_nx;
    fifo_rd_skid #(.DW(DATA_WIDTH)) u_skid (
        .clk(r_clk),
        .rst(rrst),
        .push(inflight),
        .pop(pop),
        .din(bus.data_out),
        .dout(bus.m_data),
        .occ(occ)
    );
    assign pop = bus.m_valid && bus.m_ready;
    assign bus.m_valid = occ != 2'd0;
    assign bus.m_last = bus.m_valid && beat == LAST;
    // Credit counts words already owned (buffered or in flight) after this cycle's pop.
    assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign bus.rd_req = !bus.fifo_empty && !rrst && credit < 3'd2;
    assign occ_nx = occ + {1'b0, inflight} - {1'b0, pop};
    always_comb begin
        st_nx = st_of(occ_nx, bus.rd_req);
    end
    always_ff @(posedge r_clk or posedge rrst) begin
        if (rrst) begin
            st <= IDLE;
            inflight <= 1'b0;
            beat <= '0;
        end else begin
            st <= st_nx;
            inflight <= bus.rd_req;
            if (pop) beat <= beat == LAST ? '0 : beat + 1'b1;
        end
    end
`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge r_clk or posedge rrst) begin
        if (rrst) rd_count <= '0;
        else if (pop && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
`endif
    a_state: assert property (@(posedge r_clk) disable iff (rrst) st == st_of(occ, inflight));
    a_overflow: assert property (@(posedge r_clk) disable iff (rrst) !(inflight && occ == 2'd2 && !pop));
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fill latency, framing, stall, reset and alternating ready.
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;
    logic r_clk = 1'b0;
    logic rrst = 1'b1;
    logic hold = 1'b1;
    logic inf = 1'b0;
    int rp = 0, wp = 0;
    int errors = 0, checks = 0;
    int nreq, tcyc, first_req, first_pop;
    logic [7:0] fm [256];
    logic [7:0] got_d [$];
    logic got_l [$];
`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_count;
`endif
    fifo_rd_stream_if #(.DW(DATA_WIDTH)) bus ();
    fifo_rd_stream #(.BURST_LEN(4)) dut (
        .r_clk(r_clk),
        .rrst(rrst),
        .bus(bus)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count(rd_count)
`endif
    );
    always #5 r_clk = ~r_clk;
    assign bus.fifo_empty = hold || (!inf && rp == wp);
    always @(posedge r_clk) begin
        if (bus.rd_req) begin
            bus.data_out <= fm[rp % 256];
            rp <= rp + 1;
        end
    end
    task automatic load(input logic [7:0] v);
        fm[wp % 256] = v;
        wp++;
    endtask
    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        nreq = 0;
        tcyc = 0;
        first_req = -1;
        first_pop = -1;
    endtask
    task automatic cyc(input logic rdy, input logic hld);
        @(negedge r_clk);
        bus.m_ready = rdy;
        hold = hld;
        #1;
        if (bus.rd_req) begin
            nreq++;
            if (first_req < 0) first_req = tcyc;
        end
        if (bus.m_valid && bus.m_ready) begin
            got_d.push_back(bus.m_data);
            got_l.push_back(bus.m_last);
            if (first_pop < 0) first_pop = tcyc;
        end
        tcyc++;
    endtask
    task automatic pulse_rst();
        @(negedge r_clk);
        rrst = 1'b1;
        @(negedge r_clk);
        rrst = 1'b0;
    endtask
    task automatic check_stream(input string name, input logic [7:0] base, input int n, input int last_ofs);
        checks++;
        if (got_d.size() !== n) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, got_d.size(), n);
        end
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== base + 8'(i)) begin
                errors++;
                $display("FAIL %s data[%0d]: got %02h want %02h", name, i, got_d[i], base + 8'(i));
            end
            checks++;
            if (got_l[i] !== ((i + last_ofs) % 4 == 3)) begin
                errors++;
                $display("FAIL %s last[%0d]: got %b want %b", name, i, got_l[i], (i + last_ofs) % 4 == 3);
            end
        end
    endtask
    task automatic test_reset();
        bus.m_ready = 1'b0;
        #1;
        checks++;
        if ({bus.rd_req, bus.m_valid, bus.m_last, bus.m_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {bus.rd_req, bus.m_valid, bus.m_last, bus.m_data});
        end
`ifdef FIFO_RD_STATS_EN
        checks++;
        if (rd_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_rd_count: got %0d want 0", rd_count);
        end
`endif
        @(negedge r_clk);
        rrst = 1'b0;
        clear_log();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1);
            checks++;
            if ({bus.rd_req, bus.m_valid, bus.m_last, bus.m_data} !== '0) begin
                errors++;
                $display("FAIL empty_idle cyc%0d: got %b want 0", i, {bus.rd_req, bus.m_valid, bus.m_last, bus.m_data});
            end
        end
    endtask
    task automatic test_burst();
        for (int i = 1; i <= 8; i++) load(8'(i));
        clear_log();
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0);
        check_stream("burst", 8'h01, 8, 0);
        checks++;
        if (first_pop - first_req !== 2) begin
            errors++;
            $display("FAIL burst_latency: got %0d want 2", first_pop - first_req);
        end
        checks++;
        if (nreq !== 8) begin
            errors++;
            $display("FAIL burst_reqs: got %0d want 8", nreq);
        end
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_drained: got %b want 0", bus.m_valid);
        end
    endtask
    task automatic test_stall();
        hold = 1'b1;
        for (int i = 0; i < 6; i++) load(8'h10 + 8'(i));
        clear_log();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0);
            if (i >= 2) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h10 || bus.rd_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold cyc%0d: got v=%b d=%02h req=%b want v=1 d=10 req=0", i, bus.m_valid, bus.m_data, bus.rd_req);
                end
            end
        end
        checks++;
        if (nreq !== 2) begin
            errors++;
            $display("FAIL stall_reqs: got %0d want 2", nreq);
        end
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        check_stream("stall", 8'h10, 6, 0);
    endtask
    task automatic test_reset_mid();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) load(8'h30 + 8'(i));
        pulse_rst();
        clear_log();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0);
        checks++;
        if (got_d.size() !== 2 || bus.m_valid !== 1'b1 || bus.rd_req !== 1'b0 || bus.m_data !== 8'h32) begin
            errors++;
            $display("FAIL midrst_full: got n=%0d v=%b req=%b d=%02h want n=2 v=1 req=0 d=32", got_d.size(), bus.m_valid, bus.rd_req, bus.m_data);
        end
        @(negedge r_clk);
        rrst = 1'b1;
        #1;
        checks++;
        if ({bus.rd_req, bus.m_valid, bus.m_last, bus.m_data} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b want 0", {bus.rd_req, bus.m_valid, bus.m_last, bus.m_data});
        end
        @(negedge r_clk);
        rrst = 1'b0;
        clear_log();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
        check_stream("midrst", 8'h34, 4, 0);
    endtask
    task automatic test_alternate();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) load(8'h20 + 8'(i));
        clear_log();
        for (int i = 0; i < 44; i++) cyc(i % 2 == 0, 1'b0);
        check_stream("alt", 8'h20, 16, 0);
    endtask
`ifdef FIFO_RD_STATS_EN
    task automatic test_stats();
        pulse_rst();
        inf = 1'b1;
        hold = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 70004; i++) @(negedge r_clk);
        checks++;
        if (rd_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_sat: got %h want ffff", rd_count);
        end
        rrst = 1'b1;
        #1;
        checks++;
        if (rd_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: got %h want 0", rd_count);
        end
        @(negedge r_clk);
        rrst = 1'b0;
    endtask
`endif
    initial begin
        test_reset();
        test_burst();
        test_stall();
        test_reset_mid();
        test_alternate();
`ifdef FIFO_RD_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage of the async FIFO, in the `r_clk` domain. Pulls words from the FIFO consumer side with `rd_req`/`data_out` and a fixed 1-cycle read latency. Buffers them in a 2-entry skid buffer and presents them as a valid/ready stream with `m_last` framing every `BURST_LEN` beats. Sustains one word per cycle when the FIFO is non-empty and the sink is ready.

## Interface
- `DATA_WIDTH`, pkg value: FIFO word width.
- `BURST_LEN`, 4: beats per frame, ≥2; `m_last` marks beat `BURST_LEN-1`.
- `r_clk`  in  1  read-domain clock.
- `rrst`  in  1  reset, asynchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag, synchronous to `r_clk`.
- `data_out`  in  DATA_WIDTH  FIFO read data, valid the cycle after `rd_req`.
- `rd_req`  out  1  read request to FIFO consumer side.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from sink.
- `m_last`  out  1  final beat of a frame.
- `rd_count`  out  16  accepted-beat count; present only with `FIFO_RD_STATS_EN`.

## Operation
- `rd_req` is combinational: `!fifo_empty && !rrst && (occ + inflight - pop) < 2`.
  - `occ` is the buffer occupancy, 0..2.
  - `inflight` is `rd_req` registered, 0..1.
  - `pop` is `m_valid && m_ready`.
  - The `m_ready`→`rd_req` combinational path is intended.
- When `inflight` = 1, capture `data_out` into the buffer tail at the clock edge.
- Stream side:
  - `m_data` = buffer head.
  - `m_valid` = (`occ` ≠ 0).
  - `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
- FSM, `st_t`:
  - IDLE: `occ`=0 and `inflight`=0.
  - RUN: `occ`=1, or `occ`=0 with `inflight`=1.
  - FULL: `occ`=2; no `rd_req` unless `pop`.
  - Transitions follow `occ`/`inflight` after each edge. The state is an explicit register and must equal the derived condition; this is checked by assertion.
- Beat counter `beat` is `$clog2(BURST_LEN)` bits, advancing on `pop`.
  - `m_last` = (`beat` == `BURST_LEN-1`) && `m_valid`.
  - On `pop` at `BURST_LEN-1`, `beat` wraps to 0.
- Simultaneous capture and pop: `occ` unchanged; head advances and the new word goes to the tail.
- Overflow (capture with `occ`=2 and no `pop`) cannot occur by construction; an assertion flags it.
- `fifo_empty` rising while `inflight`=1: the in-flight word is still captured.

## Timing
- Reset values: `rd_req`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `rd_count`=0.
  - Internal state is cleared: `occ`=0, `inflight`=0, `beat`=0, state IDLE.
- Reset mid-operation: buffered and in-flight words are discarded, and `beat` restarts at 0.
- Latency: `rd_req` in cycle N → `data_out` sampled at end of N+1 → `m_valid` high in N+2.
- Throughput: 1 beat/cycle with continuous `m_ready` and non-empty FIFO, after the 2-cycle fill.
- `m_ready` low for k cycles: at most 2 words buffered, and `rd_req` stays 0 while FULL.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - Adds `rd_count`, incrementing on each `pop`.
  - Saturates at 16'hFFFF with no wrap.
  - Cleared only by `rrst`.
- Undefined: the `rd_count` port and its counter logic are absent.
- All other behaviour is identical in both builds.

## Structure
- Shared package `pkg`:
  - `DATA_WIDTH`.
  - `BURST_LEN_DEF` = 4.
  - `typedef enum logic [1:0] {IDLE, RUN, FULL} st_t`.
- Sub-module `fifo_rd_skid`: 2-entry buffer with push/pop and head/tail pointers, exposing `occ`.
- The top level holds the credit logic, FSM, beat counter and stats.

## Test plan
- Reset then `fifo_empty`=1 for 10 cycles → `rd_req`=0 and `m_valid`=0 throughout; all outputs 0.
- FIFO preloaded with 0x01..0x08, `m_ready`=1, `BURST_LEN`=4 → `m_data` 0x01..0x08 on consecutive cycles starting 2 cycles after the first `rd_req`; `m_last` on 0x04 and 0x08.
- FIFO holds 0x10..0x15, `m_ready` held 0 for 6 cycles then 1 → `rd_req` pulses exactly twice and then FULL; `m_data`=0x10 stable; stream resumes 0x10..0x15 in order with no loss or duplication.
- `rrst` asserted after 2 of 4 beats of a frame with the buffer full → outputs 0 immediately; after release, a new frame's first beat has `beat`=0 and `m_last` on its 4th beat.
- Alternating `m_ready` 1/0 with a 0x20..0x2F stream → exact order preserved; `m_last` every 4th accepted beat.
- `FIFO_RD_STATS_EN`, 70000 accepted beats → `rd_count`=16'hFFFF; after `rrst` → 0.
